core_requester: RTL and testbench

Initiator that feeds the division/root compute core one operation at a time and returns each result on a ready/valid response port. It buffers commands in a small FIFO, drives the core's `in_valid`/`in_mode`/operand inputs, holds `in_mode` stable until the result is captured, enforces a timeout, and clears the core's level-held `out_valid` through a core-reset pulse. It sits between the test/host sequencer and the compute core.

---
 rtl/core_req_pkg.sv | 31 +++
 rtl/core_req_fifo.sv | 52 +++++
 rtl/core_requester.sv | 147 ++++++++++++++
 tb/tb_core_requester.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_req_pkg.sv
// Shared types and constants for the division/root core requester.
// Holds the FSM state encoding, mode values, operand/result widths and the
// packed command record stored in the command FIFO.
package core_req_pkg;

    localparam int unsigned D1_W   = 10;
    localparam int unsigned D2_W   = 3;
    localparam int unsigned RES_W  = 20;
    localparam int unsigned TCNT_W = 8;

    localparam logic MODE_DIV  = 1'b0;
    localparam logic MODE_ROOT = 1'b1;

    // One queued operation: mode plus both operands (14 bits).
    typedef struct packed {
        logic            mode;
        logic [D1_W-1:0] d1;
        logic [D2_W-1:0] d2;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/core_req_fifo.sv
// Synchronous command FIFO with full/empty flags.
// Ports: clk, rst (sync, active-high), push/din, pop/dout (show-ahead), full, empty.
// Push is ignored when full, pop is ignored when empty.
module core_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Refusal on full holds even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/core_requester.sv
// Initiator feeding the division/root core one operation at a time.
// Ports: cmd_* (ready/valid command in), core_* (core start/operands/reset and
// level-held result in), rsp_* (ready/valid response out), timeout_cnt.
// Commands are buffered in a FIFO; the core's sticky out_valid is cleared by a
// one-cycle core reset pulse after every response handshake.
module core_requester
    import core_req_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [D1_W-1:0]   cmd_data_1,
    input  logic [D2_W-1:0]   cmd_data_2,
    output logic              core_rst_n,
    output logic              core_in_valid,
    output logic              core_in_mode,
    output logic [D1_W-1:0]   core_in_data_1,
    output logic [D2_W-1:0]   core_in_data_2,
    input  logic              core_out_valid,
    input  logic [RES_W-1:0]  core_out_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_mode,
    output logic              rsp_timeout,
    output logic [TCNT_W-1:0] timeout_cnt
);

    localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    state_t            state_next;
    logic [WCNT_W-1:0] wait_cnt;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              got_result;
    logic              timed_out;
    cmd_t              fifo_din;
    cmd_t              fifo_dout;

    assign fifo_din  = '{mode: cmd_mode, d1: cmd_data_1, d2: cmd_data_2};
    assign cmd_ready = !fifo_full && !rst;

    core_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state, FIFO pop and WAIT outcome; a result beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        got_result = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (core_out_valid) begin
                    got_result = 1'b1;
                    state_next = ST_RESP;
                end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_CLEAR;
            end
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they line up with it.
    // The core_in_* registers double as the operation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt       <= '0;
            core_rst_n     <= 1'b0;
            core_in_valid  <= 1'b0;
            core_in_mode   <= 1'b0;
            core_in_data_1 <= '0;
            core_in_data_2 <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_mode       <= 1'b0;
            rsp_timeout    <= 1'b0;
            timeout_cnt    <= '0;
        end else begin
            core_rst_n    <= (state_next != ST_CLEAR);
            core_in_valid <= (state_next == ST_ISSUE);
            rsp_valid     <= (state_next == ST_RESP);

            if (fifo_pop) begin
                core_in_mode   <= fifo_dout.mode;
                core_in_data_1 <= fifo_dout.d1;
                core_in_data_2 <= fifo_dout.d2;
            end else if (state_next == ST_CLEAR || state_next == ST_IDLE) begin
                core_in_mode   <= 1'b0;
                core_in_data_1 <= '0;
                core_in_data_2 <= '0;
            end

            if (state == ST_ISSUE)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + WCNT_W'(1);

            if (got_result) begin
                rsp_data    <= core_out_data;
                rsp_mode    <= core_in_mode;
                rsp_timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_data    <= '0;
                rsp_mode    <= core_in_mode;
                rsp_timeout <= 1'b1;
                if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + TCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_requester.sv
// Self-checking bench for core_requester: directed commands, a behavioural core
// model with per-command latency, and a scoreboard monitor on the response port.
module tb_core_requester;
    import core_req_pkg::*;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [9:0]  cmd_data_1;
    logic [2:0]  cmd_data_2;
    logic        core_rst_n;
    logic        core_in_valid;
    logic        core_in_mode;
    logic [9:0]  core_in_data_1;
    logic [2:0]  core_in_data_2;
    logic        core_out_valid = 1'b0;
    logic [19:0] core_out_data = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [19:0] rsp_data;
    logic        rsp_mode;
    logic        rsp_timeout;
    logic [7:0]  timeout_cnt;

    core_requester #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_data_1(cmd_data_1), .cmd_data_2(cmd_data_2),
        .core_rst_n(core_rst_n), .core_in_valid(core_in_valid), .core_in_mode(core_in_mode),
        .core_in_data_1(core_in_data_1), .core_in_data_2(core_in_data_2),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mode(rsp_mode), .rsp_timeout(rsp_timeout), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [19:0] res;
        logic        mode;
        logic [9:0]  d1;
        logic [2:0]  d2;
    } op_t;

    typedef struct packed {
        logic        mode;
        logic [19:0] data;
        logic        to;
    } exp_t;

    op_t  mq[$];
    exp_t sq[$];
    exp_t se;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int iv_count = 0, last_iv = -1, low_count = 0, last_low = -1;
    int rsp_count = 0, rsp_rise = -1, last_hs = -1;
    logic rsp_prev = 1'b0;
    logic win = 1'b0;
    logic cur_mode;
    logic [9:0] cur_d1;

    logic        cm_busy = 1'b0;
    int          cm_rem = 0;
    logic [19:0] cm_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Core model: result appears lat cycles after the in_valid cycle; lat 0 never answers.
    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_out_valid <= 1'b0;
            cm_busy        <= 1'b0;
        end else if (core_in_valid) begin
            if (mq.size() != 0) begin
                if (mq[0].lat != 0) begin
                    cm_busy <= 1'b1;
                    cm_rem  <= mq[0].lat - 1;
                    cm_res  <= mq[0].res;
                end
                void'(mq.pop_front());
            end
        end else if (cm_busy && cm_rem == 1) begin
            core_out_valid <= 1'b1;
            core_out_data  <= cm_res;
            cm_busy        <= 1'b0;
        end else if (cm_busy) begin
            cm_rem <= cm_rem - 1;
        end
    end

    // Monitor: issue checks, operand hold, core reset pulses, response scoreboard.
    always @(negedge clk) begin
        if (core_in_valid) begin
            iv_count++;
            last_iv = cyc;
            if (mq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL issue: unexpected core_in_valid d1=%0d", core_in_data_1);
            end else begin
                check("issue_mode", 32'(core_in_mode), 32'(mq[0].mode));
                check("issue_d1", 32'(core_in_data_1), 32'(mq[0].d1));
                check("issue_d2", 32'(core_in_data_2), 32'(mq[0].d2));
                win      = 1'b1;
                cur_mode = mq[0].mode;
                cur_d1   = mq[0].d1;
            end
        end else if (win && core_rst_n) begin
            check("mode_hold", 32'(core_in_mode), 32'(cur_mode));
            check("d1_hold", 32'(core_in_data_1), 32'(cur_d1));
        end
        if (!core_rst_n) begin
            win = 1'b0;
            low_count++;
            last_low = cyc;
        end
        if (rsp_valid && !rsp_prev) rsp_rise = cyc;
        rsp_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            last_hs = cyc;
            rsp_count++;
            if (sq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp: unexpected response data=%0h", rsp_data);
            end else begin
                se = sq.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(se.data));
                check("rsp_mode", 32'(rsp_mode), 32'(se.mode));
                check("rsp_timeout", 32'(rsp_timeout), 32'(se.to));
            end
        end
    end

    // Offer one command for one cycle; queue model entry and expected response if accepted.
    task automatic push(input logic m, input logic [9:0] d1, input logic [2:0] d2,
                        input int lat, input logic [19:0] res, output logic acc, output int pc);
        op_t  o;
        exp_t e;
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_data_1 = d1;
        cmd_data_2 = d2;
        acc = cmd_ready;
        pc  = cyc;
        if (acc) begin
            o.lat = lat; o.res = res; o.mode = m; o.d1 = d1; o.d2 = d2;
            mq.push_back(o);
            e.mode = m;
            e.to   = (lat == 0 || lat > int'(TO));
            e.data = e.to ? 20'h0 : res;
            sq.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_count < n && k < 300) begin @(posedge clk); #1; k++; end
        tests++;
        if (rsp_count < n) begin
            fails++;
            $display("FAIL %s: timed out with %0d responses, required %0d", name, rsp_count, n);
        end
    endtask

    logic acc;
    int   pc, iv0, low0, k;
    logic accs [5];
    logic [19:0] sd;
    logic sm, st, stable;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_data_1 = '0; cmd_data_2 = '0;
        rsp_ready = 1'b1;
        cycles(3);
        check("rst_core_rst_n", 32'(core_rst_n), 32'(0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_in_valid", 32'(core_in_valid), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'(0));
        rst = 1'b0;
        cycles(1);
        check("post_rst_core_rst_n", 32'(core_rst_n), 32'(1));
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

        // Single division.
        iv0 = iv_count; low0 = low_count;
        push(MODE_DIV, 10'd100, 3'd7, 5, 20'h0ABCD, acc, pc);
        check("div_accept", 32'(acc), 32'(1));
        wait_rsp(1, "div_wait");
        cycles(3);
        check("div_iv_pulses", 32'(iv_count - iv0), 32'(1));
        check("div_issue_latency", 32'(last_iv), 32'(pc + 2));
        check("div_rsp_latency", 32'(rsp_rise), 32'(last_iv + 6));
        check("div_clear_pos", 32'(last_low), 32'(last_hs + 1));
        check("div_clear_len", 32'(low_count - low0), 32'(1));

        // Root with mode hold (checked every cycle by the monitor).
        push(MODE_ROOT, 10'd1023, 3'd0, 3, 20'hFFFFF, acc, pc);
        wait_rsp(2, "root_wait");
        cycles(3);
        check("root_mode_cleared", 32'(core_in_mode), 32'(0));

        // FIFO full while an operation is in progress.
        iv0 = iv_count;
        push(MODE_DIV, 10'd1, 3'd1, 7, 20'h11111, acc, pc);
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            push(MODE_DIV, 10'(20 + i), 3'(i), 3, 20'(32'h200 + i), acc, pc);
            accs[i] = acc;
        end
        for (int i = 0; i < 5; i++) check("full_accept", 32'(accs[i]), 32'(i < 4 ? 1 : 0));
        wait_rsp(7, "full_wait");
        cycles(4);
        check("full_iv_pulses", 32'(iv_count - iv0), 32'(5));
        check("full_model_drained", 32'(mq.size()), 32'(0));

        // Timeout.
        push(MODE_DIV, 10'd5, 3'd1, 0, 20'h0, acc, pc);
        wait_rsp(8, "to_wait");
        check("to_rsp_latency", 32'(rsp_rise), 32'(last_iv + int'(TO) + 1));
        check("to_count", 32'(timeout_cnt), 32'(1));
        cycles(3);

        // Backpressure: response held, next command stays queued.
        rsp_ready = 1'b0;
        push(MODE_ROOT, 10'd50, 3'd2, 3, 20'h12345, acc, pc);
        push(MODE_DIV, 10'd60, 3'd3, 4, 20'h54321, acc, pc);
        k = 0;
        while (!rsp_valid && k < 50) begin cycles(1); k++; end
        check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        check("bp_rsp_data", 32'(rsp_data), 32'h12345);
        iv0 = iv_count; sd = rsp_data; sm = rsp_mode; st = rsp_timeout; stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== sd || rsp_mode !== sm || rsp_timeout !== st)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'(1));
        check("bp_no_issue", 32'(iv_count - iv0), 32'(0));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_rsp(10, "bp_wait");
        cycles(3);

        // Result arriving exactly at the last wait cycle wins over timeout.
        push(MODE_DIV, 10'd70, 3'd4, int'(TO), 20'h0BEEF, acc, pc);
        wait_rsp(11, "race_wait");
        check("race_rsp_latency", 32'(rsp_rise), 32'(last_iv + int'(TO) + 1));
        check("race_timeout_cnt", 32'(timeout_cnt), 32'(1));
        cycles(3);

        // Reset in WAIT with two commands queued.
        push(MODE_DIV, 10'd80, 3'd5, 0, 20'h0, acc, pc);
        cycles(4);
        push(MODE_ROOT, 10'd90, 3'd6, 3, 20'h00123, acc, pc);
        push(MODE_DIV, 10'd91, 3'd7, 3, 20'h00456, acc, pc);
        iv0 = iv_count;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_core_rst_n", 32'(core_rst_n), 32'(0));
        mq.delete();
        sq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(1);
        check("after_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("after_rst_timeout_cnt", 32'(timeout_cnt), 32'(0));
        check("after_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        cycles(20);
        check("after_rst_no_issue", 32'(iv_count - iv0), 32'(0));
        check("after_rst_no_rsp", 32'(rsp_count), 32'(11));

        // A fresh command is the next one served.
        push(MODE_DIV, 10'd99, 3'd1, 2, 20'h00777, acc, pc);
        wait_rsp(12, "fresh_wait");
        cycles(3);
        check("final_scoreboard_empty", 32'(sq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d responses", rsp_count);
        $fatal(1);
    end

endmodule
